// File: rtl/avg_pool2d_scheduler.sv
// Address and window-tap scheduler for a 2-D average-pooling pass.
// Walks every KxK window of a WxH feature map in raster order, one tap per
// valid/ready transfer, and flags the first and last tap of each window.
module avg_pool2d_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  cfg_width,
  input  logic [7:0]  cfg_height,
  input  logic [3:0]  cfg_kernel,
  input  logic [3:0]  cfg_stride,
  output logic        addr_valid,
  input  logic        addr_ready,
  output logic [15:0] addr,
  output logic        tap_first,
  output logic        tap_last,
  output logic [7:0]  win_x,
  output logic [7:0]  win_y,
  output logic [7:0]  win_div,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [7:0]  w_q, h_q;
  logic [3:0]  k_q, s_q;
  logic [7:0]  win_div_q;
  logic [3:0]  kx_q, ky_q;
  logic [7:0]  col_base_q, row_base_q;
  logic [7:0]  win_x_q, win_y_q;
  logic [15:0] addr_q;
  logic        addr_valid_q, tap_first_q, tap_last_q;
  logic        done_q, cfg_err_q;

  logic [3:0]  kx_d, ky_d;
  logic [7:0]  col_base_d, row_base_d, win_x_d, win_y_d;
  logic [15:0] addr_d;
  logic        tap_first_d, tap_last_d;
  logic        pass_end, xfer, finish_run, cfg_ok;
  logic [9:0]  col_reach, row_reach;
  logic [7:0]  row_idx, col_idx;
  logic [7:0]  kernel_sq;

  // Next tap position, its address and window flags, plus start-time checks.
  always_comb begin
    kx_d        = kx_q;
    ky_d        = ky_q;
    col_base_d  = col_base_q;
    row_base_d  = row_base_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    pass_end    = 1'b0;
    col_reach   = {2'b00, col_base_q} + {6'b0, s_q} + {6'b0, k_q};
    row_reach   = {2'b00, row_base_q} + {6'b0, s_q} + {6'b0, k_q};

    // Next-window tests replace a divide: a further window fits only if
    // base+S+K stays within the map edge.
    if (kx_q != k_q - 4'd1) begin
      kx_d = kx_q + 4'd1;
    end else begin
      kx_d = '0;
      if (ky_q != k_q - 4'd1) begin
        ky_d = ky_q + 4'd1;
      end else begin
        ky_d = '0;
        if (col_reach <= {2'b00, w_q}) begin
          col_base_d = col_base_q + {4'b0, s_q};
          win_x_d    = win_x_q + 8'd1;
        end else begin
          col_base_d = '0;
          win_x_d    = '0;
          if (row_reach <= {2'b00, h_q}) begin
            row_base_d = row_base_q + {4'b0, s_q};
            win_y_d    = win_y_q + 8'd1;
          end else begin
            pass_end = 1'b1;
          end
        end
      end
    end

    row_idx     = row_base_d + {4'b0, ky_d};
    col_idx     = col_base_d + {4'b0, kx_d};
    addr_d      = ({8'b0, row_idx} * {8'b0, w_q}) + {8'b0, col_idx};
    tap_first_d = (kx_d == 4'd0) && (ky_d == 4'd0);
    tap_last_d  = (kx_d == k_q - 4'd1) && (ky_d == k_q - 4'd1);

    xfer       = addr_valid_q && addr_ready;
    finish_run = (state_q == RUN) && (abort || (xfer && pass_end));

    cfg_ok    = (cfg_kernel != 4'd0) && (cfg_stride != 4'd0) &&
                ({4'b0, cfg_kernel} <= cfg_width) &&
                ({4'b0, cfg_kernel} <= cfg_height);
    kernel_sq = {4'b0, cfg_kernel} * {4'b0, cfg_kernel};
  end

  // FSM with registered tap outputs; abort outranks a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      k_q          <= '0;
      s_q          <= '0;
      win_div_q    <= '0;
      kx_q         <= '0;
      ky_q         <= '0;
      col_base_q   <= '0;
      row_base_q   <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      tap_first_q  <= 1'b0;
      tap_last_q   <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_q      <= RUN;
              w_q          <= cfg_width;
              h_q          <= cfg_height;
              k_q          <= cfg_kernel;
              s_q          <= cfg_stride;
              win_div_q    <= kernel_sq;
              kx_q         <= '0;
              ky_q         <= '0;
              col_base_q   <= '0;
              row_base_q   <= '0;
              win_x_q      <= '0;
              win_y_q      <= '0;
              addr_q       <= '0;
              addr_valid_q <= 1'b1;
              tap_first_q  <= 1'b1;
              tap_last_q   <= (cfg_kernel == 4'd1);
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (finish_run) begin
            state_q      <= IDLE;
            done_q       <= !abort;
            kx_q         <= '0;
            ky_q         <= '0;
            col_base_q   <= '0;
            row_base_q   <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            tap_first_q  <= 1'b0;
            tap_last_q   <= 1'b0;
          end else if (xfer) begin
            kx_q        <= kx_d;
            ky_q        <= ky_d;
            col_base_q  <= col_base_d;
            row_base_q  <= row_base_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            addr_q      <= addr_d;
            tap_first_q <= tap_first_d;
            tap_last_q  <= tap_last_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_valid = addr_valid_q;
  assign addr       = addr_q;
  assign tap_first  = tap_first_q;
  assign tap_last   = tap_last_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign win_div    = win_div_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_avg_pool2d_scheduler.sv
// Self-checking bench for avg_pool2d_scheduler: a tap-list model built from
// nested window loops, checked against every presented tap.
module tb_avg_pool2d_scheduler;

  logic        clk, rst, start, abort;
  logic [7:0]  cfg_width, cfg_height;
  logic [3:0]  cfg_kernel, cfg_stride;
  logic        addr_valid, addr_ready;
  logic [15:0] addr;
  logic        tap_first, tap_last;
  logic [7:0]  win_x, win_y, win_div;
  logic        busy, done, cfg_err;

  avg_pool2d_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .tap_first(tap_first), .tap_last(tap_last),
    .win_x(win_x), .win_y(win_y), .win_div(win_div),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [15:0] a;
    logic        f;
    logic        l;
    logic [7:0]  x;
    logic [7:0]  y;
  } tap_t;

  tap_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   pops   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected tap list straight from the pooling definition.
  task automatic build(input int w, input int h, input int k, input int s);
    int nx, ny;
    tap_t t;
    exp_q.delete();
    nx = (w - k) / s + 1;
    ny = (h - k) / s + 1;
    for (int wy = 0; wy < ny; wy++)
      for (int wx = 0; wx < nx; wx++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            t.a = 16'((wy * s + ky) * w + wx * s + kx);
            t.f = (kx == 0) && (ky == 0);
            t.l = (kx == k - 1) && (ky == k - 1);
            t.x = 8'(wx);
            t.y = 8'(wy);
            exp_q.push_back(t);
          end
  endtask

  // Compare every presented tap with the head of the model list.
  always @(negedge clk) begin
    if (!rst && addr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_tap: got addr 0x%0h expected no tap", addr);
      end else begin
        chk("tap", {addr, tap_first, tap_last, win_x, win_y}, exp_q[0]);
        chk("busy_with_valid", busy, 1);
        if (addr_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic launch(input int w, input int h, input int k, input int s, input logic with_abort);
    cfg_width  = 8'(w);
    cfg_height = 8'(h);
    cfg_kernel = 4'(k);
    cfg_stride = 4'(s);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("win_div", win_div, 64'(k * k));
  endtask

  task automatic wait_done(input int stall_at, input int stall_len, input int poke_at);
    int  cyc = 0;
    bit  ok  = 0;
    while (!ok && cyc < 2000) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) ok = 1;
      else begin
        addr_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
        start = (cyc == poke_at);
        if (cyc == poke_at) begin
          cfg_width  = 8'd9;
          cfg_kernel = 4'd1;
          cfg_stride = 4'd1;
        end
        cyc++;
      end
    end
    start = 1'b0;
    addr_ready = 1'b1;
    if (!ok) begin
      checks++;
      $display("FAIL pass_timeout: got %0d taps left expected 0", exp_q.size());
    end
    @(negedge clk);
    chk("done_pulse", {done, addr_valid, busy}, 3'b100);
    @(negedge clk);
    chk("done_one_cycle", {done, addr_valid, busy}, 3'b000);
  endtask

  task automatic wait_pops(input int base, input int n);
    int cyc = 0;
    while ((pops - base) < n && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if ((pops - base) < n) begin
      checks++;
      $display("FAIL pops_timeout: got %0d expected %0d", pops - base, n);
    end
  endtask

  initial begin
    int first5[9];
    int base;
    first5 = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
    cfg_width = '0; cfg_height = '0; cfg_kernel = '0; cfg_stride = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {addr_valid, addr, tap_first, tap_last, win_x, win_y,
                          win_div, busy, done, cfg_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 4x4, K=2, S=2
    build(4, 4, 2, 2);
    chk("model_4x4_w0", {exp_q[0].a, exp_q[1].a, exp_q[2].a, exp_q[3].a}, {16'd0, 16'd1, 16'd4, 16'd5});
    chk("model_4x4_w1", {exp_q[4].a, exp_q[5].a, exp_q[6].a, exp_q[7].a}, {16'd2, 16'd3, 16'd6, 16'd7});
    chk("model_4x4_last", {16'(exp_q.size()), exp_q[15].a}, {16'd16, 16'd15});
    launch(4, 4, 2, 2, 1'b0);
    wait_done(1000, 0, -1);

    // 5x5, K=3, S=1
    build(5, 5, 3, 1);
    chk("model_5x5_size", exp_q.size(), 81);
    for (int i = 0; i < 9; i++) chk("model_5x5_w0", exp_q[i].a, 64'(first5[i]));
    chk("model_5x5_final", {exp_q[80].a, exp_q[80].l, exp_q[80].x, exp_q[80].y},
        {16'd24, 1'b1, 8'd2, 8'd2});
    launch(5, 5, 3, 1, 1'b0);
    wait_done(1000, 0, -1);

    // 7x3, K=3, S=2: stall mid-window, ignored start with new cfg mid-pass
    build(7, 3, 3, 2);
    chk("model_7x3", {16'(exp_q.size()), exp_q[9].a, exp_q[18].a}, {16'd27, 16'd2, 16'd4});
    launch(7, 3, 3, 2, 1'b0);
    wait_done(4, 3, 10);

    // Invalid configurations
    cfg_width = 8'd4; cfg_height = 8'd4; cfg_kernel = 4'd5; cfg_stride = 4'd1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("cfg_err_k_gt_w", {cfg_err, busy, addr_valid}, 3'b100);
    @(negedge clk);
    chk("cfg_err_one_cycle", {cfg_err, busy}, 2'b00);
    cfg_kernel = 4'd2; cfg_stride = 4'd0;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("cfg_err_s0", {cfg_err, busy, addr_valid}, 3'b100);

    // Abort in IDLE is ignored
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, addr_valid, done, cfg_err}, 0);

    // K=1 2x2, started together with abort
    build(2, 2, 1, 1);
    chk("model_k1", {16'(exp_q.size()), exp_q[0].f, exp_q[0].l, exp_q[3].f, exp_q[3].l},
        {16'd4, 4'b1111});
    launch(2, 2, 1, 1, 1'b1);
    wait_done(1000, 0, -1);

    // Abort on the 7th tap of 4x4, coincident with a transfer
    build(4, 4, 2, 2);
    base = pops;
    launch(4, 4, 2, 2, 1'b0);
    wait_pops(base, 6);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_run", {addr_valid, busy, done}, 3'b000);
    @(negedge clk);
    chk("abort_no_done", {addr_valid, busy, done}, 3'b000);

    // Reset mid-pass
    build(4, 4, 2, 2);
    base = pops;
    launch(4, 4, 2, 2, 1'b0);
    wait_pops(base, 5);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("reset_midpass", {addr_valid, addr, tap_first, tap_last, win_x, win_y,
                          win_div, busy, done, cfg_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_no_done", {done, busy}, 2'b00);

    // Full pass after reset
    build(4, 4, 2, 2);
    launch(4, 4, 2, 2, 1'b0);
    wait_done(1000, 0, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
